// File: rtl/alu_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// alu_mdu_ctrl
//
// EX-stage ALU decoder and iterative multiply/divide unit with HI/LO registers.
// The aluop/funct pair is decoded into a 3-bit ALU control word. The same
// decode drives a radix-2 shift-add multiplier and a restoring divider. These
// handle mult, multu, div and divu. mfhi, mflo, mthi and mtlo access the
// HI/LO registers. A pipeline stall is raised while HI/LO are still being
// computed.
//
// Optional feature:
//   MDU_EARLY_OUT_EN - when defined, a multiply leaves the MUL state as soon
//                      as the remaining multiplier bits are all zero.
//
// Parameters:
//   WIDTH      datapath width of srca/srcb/HI/LO (>= 4)
//   CNT_W      iteration counter width
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   valid      EX-stage instruction valid
//   aluop      main-decoder ALU op
//   funct      R-type funct field
//   srca       operand rs
//   srcb       operand rt
//   alucontrol ALU control (combinational)
//   res_sel    result mux select: 00 ALU, 01 HI, 10 LO
//   illegal    unrecognised R-type funct while valid
//   stall      hold the pipeline this cycle
//   busy       multiply/divide in progress
//   hi         HI register
//   lo         LO register
// ---------------------------------------------------------------------------
module alu_mdu_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [2:0]       alucontrol,
  output logic [1:0]       res_sel,
  output logic             illegal,
  output logic             stall,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod, mcand, prod_add, prod_fix;
  logic [WIDTH-1:0]   mplier, rem, quo, divisor;
  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               a_neg, b_neg, neg_q, neg_r, dz, op_div;
  logic               is_mdu, is_start, start, wr_hi, wr_lo, mul_last;

  // Instruction decode. This is purely a function of aluop/funct/valid, so
  // the ALU path and the illegal flag never see the MDU state.
  always_comb begin
    alucontrol = 3'b010;
    res_sel    = 2'b00;
    illegal    = 1'b0;
    is_mdu     = 1'b0;
    is_start   = 1'b0;
    if (aluop == 2'b01) begin
      alucontrol = 3'b110;
    end else if (aluop[1]) begin
      case (funct)
        F_ADD:  alucontrol = 3'b010;
        F_SUB:  alucontrol = 3'b110;
        F_AND:  alucontrol = 3'b000;
        F_OR:   alucontrol = 3'b001;
        F_SLT:  alucontrol = 3'b111;
        F_MFHI: begin
          res_sel = 2'b01;
          is_mdu  = 1'b1;
        end
        F_MFLO: begin
          res_sel = 2'b10;
          is_mdu  = 1'b1;
        end
        F_MTHI, F_MTLO: is_mdu = 1'b1;
        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
          is_mdu   = 1'b1;
          is_start = 1'b1;
        end
        default: illegal = valid;
      endcase
    end
  end

  assign busy  = (state != IDLE);
  assign stall = valid & aluop[1] & busy & is_mdu;
  assign start = valid & aluop[1] & is_start & (state == IDLE);
  assign wr_hi = valid & aluop[1] & (funct == F_MTHI) & ~stall;
  assign wr_lo = valid & aluop[1] & (funct == F_MTLO) & ~stall;

  // Operand magnitudes. funct[0] is clear for the signed forms (mult, div),
  // so only those take absolute values; the signs are reapplied in FIX.
  always_comb begin
    a_neg = ~funct[0] & srca[WIDTH-1];
    b_neg = ~funct[0] & srcb[WIDTH-1];
    a_mag = a_neg ? (~srca + 1'b1) : srca;
    b_mag = b_neg ? (~srcb + 1'b1) : srcb;
  end

  // One step of each iterative datapath plus the final sign correction.
  // The divider shifts the next dividend bit into the partial remainder.
  // The top bit of the trial subtraction then acts as the borrow.
  always_comb begin
    prod_add  = mplier[0] ? (prod + mcand) : prod;
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, divisor};
    prod_fix  = neg_q ? (~prod + 1'b1) : prod;
    quo_fix   = neg_q ? (~quo + 1'b1) : quo;
    rem_fix   = neg_r ? (~rem + 1'b1) : rem;
  end

  // Last multiply iteration. With early-out, stop once the multiplier bits
  // still to be shifted in are all zero; the product can no longer change.
`ifdef MDU_EARLY_OUT_EN
  assign mul_last = (cnt == CNT_ONE) || (mplier[WIDTH-1:1] == '0);
`else
  assign mul_last = (cnt == CNT_ONE);
`endif

  // Next-state logic for the MDU sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = funct[1] ? DIV : MUL;
      MUL:  if (mul_last) state_nxt = FIX;
      DIV:  if (cnt == CNT_ONE) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and HI/LO registers. mthi/mtlo can only write while
  // idle, because in any busy state they raise stall themselves. This means
  // they can never collide with the FIX write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      op_div  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_hi) hi <= srca;
      if (wr_lo) lo <= srca;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= CNT_INIT;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            dz      <= (srcb == '0);
            op_div  <= funct[1];
            prod    <= '0;
            mcand   <= {{WIDTH{1'b0}}, a_mag};
            mplier  <= b_mag;
            rem     <= '0;
            quo     <= a_mag;
            divisor <= b_mag;
          end
        end
        MUL: begin
          prod   <= prod_add;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_ONE;
        end
        DIV: begin
          if (!div_diff[WIDTH+1]) begin
            rem <= div_diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= div_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt - CNT_ONE;
        end
        FIX: begin
          // With a zero divisor every trial subtraction succeeds. The
          // quotient is then all ones and the remainder is |srca|. The
          // remainder sign fix turns that back into srca, so only LO needs
          // forcing.
          if (op_div) begin
            hi <= rem_fix;
            lo <= dz ? '1 : quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_ctrl
//
// Scoreboard testbench for alu_mdu_ctrl (WIDTH=32). Every issued
// multiply/divide pushes its expected HI/LO and completion edge into a
// queue. A monitor pops an entry each time busy falls and compares it.
// Directed decode, stall, mthi/mtlo and reset checks run inline.
// The bench honours MDU_EARLY_OUT_EN in its latency model.
// ---------------------------------------------------------------------------
module tb_alu_mdu_ctrl;

  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid = 1'b0;
  logic [1:0]   aluop = 2'b00;
  logic [5:0]   funct = 6'b000000;
  logic [W-1:0] srca  = '0;
  logic [W-1:0] srcb  = '0;
  logic [2:0]   alucontrol;
  logic [1:0]   res_sel;
  logic         illegal, stall, busy;
  logic [W-1:0] hi, lo;

  alu_mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .aluop(aluop), .funct(funct),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .res_sel(res_sel),
    .illegal(illegal), .stall(stall), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  // Rising-edge counter used to express expected completion times.
  always @(posedge clk) edges = edges + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           done_edge;
    string        tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic busy_q = 1'b0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic, written from the MIPS semantics using native
  // 64-bit and 32-bit operators rather than any bit-serial algorithm.
  function automatic void refModel(input logic [5:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] rhi,
                                   output logic [W-1:0] rlo, output int lat);
    longint          sp;
    longint unsigned up;
    int              ia, ib;
    logic [W-1:0]    mag;
    int              k;
    ia  = a;
    ib  = b;
    rhi = '0;
    rlo = '0;
    case (f)
      F_MULT: begin
        sp = longint'(ia) * longint'(ib);
        {rhi, rlo} = sp;
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        {rhi, rlo} = up;
      end
      F_DIV: begin
        if (b == '0) begin
          rhi = a;
          rlo = '1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          rhi = '0;
          rlo = 32'h8000_0000;
        end else begin
          rlo = ia / ib;
          rhi = ia % ib;
        end
      end
      default: begin
        if (b == '0) begin
          rhi = a;
          rlo = '1;
        end else begin
          rlo = a / b;
          rhi = a % b;
        end
      end
    endcase
    lat = W + 1;
`ifdef MDU_EARLY_OUT_EN
    if (f == F_MULT || f == F_MULTU) begin
      mag = (f == F_MULT && b[W-1]) ? -b : b;
      k = 0;
      for (int i = 0; i < W; i++) if (mag[i]) k = i;
      lat = k + 2;
    end
`else
    mag = '0;
    k   = 0;
    if (mag != '0) lat = k;
`endif
  endfunction

  // Expected decode, straight from the opcode table.
  function automatic void expDecode(input logic [1:0] op, input logic [5:0] f,
                                    input logic v, output logic [2:0] ea,
                                    output logic [1:0] es, output logic ei);
    ea = 3'b010;
    es = 2'b00;
    ei = 1'b0;
    if (op == 2'b01) ea = 3'b110;
    else if (op[1]) begin
      case (f)
        F_SUB:  ea = 3'b110;
        F_AND:  ea = 3'b000;
        F_OR:   ea = 3'b001;
        F_SLT:  ea = 3'b111;
        F_MFHI: es = 2'b01;
        F_MFLO: es = 2'b10;
        F_ADD, F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: ;
        default: ei = v;
      endcase
    end
  endfunction

  // Monitor: every falling busy is a completed operation.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_q = 1'b0;
    end else begin
      if (busy_q && !busy) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected completion: actual=1 required=0");
        end else begin
          mon_e = sbq.pop_front();
          checkOutput({mon_e.tag, " hi"}, hi, mon_e.hi);
          checkOutput({mon_e.tag, " lo"}, lo, mon_e.lo);
          checkOutput({mon_e.tag, " done edge"}, edges, mon_e.done_edge);
        end
      end
      busy_q = busy;
    end
  end

  // Decode check while idle; valid drops again before the next rising edge.
  task automatic decodeCheck(input logic [1:0] op, input logic [5:0] f, input logic v);
    logic [2:0] ea;
    logic [1:0] es;
    logic       ei;
    expDecode(op, f, v, ea, es, ei);
    @(negedge clk);
    aluop = op;
    funct = f;
    valid = v;
    #1;
    checkOutput($sformatf("alucontrol op=%b f=%b", op, f), alucontrol, ea);
    checkOutput($sformatf("res_sel op=%b f=%b", op, f), res_sel, es);
    checkOutput($sformatf("illegal op=%b f=%b v=%b", op, f, v), illegal, ei);
    checkOutput("idle stall", stall, 1'b0);
    valid = 1'b0;
    #1;
  endtask

  // Issue one MDU op for a single cycle and queue its expected result.
  task automatic applyStimulus(input logic [5:0] f, input logic [W-1:0] a,
                               input logic [W-1:0] b, input string tag);
    exp_t e;
    int   lat;
    @(negedge clk);
    refModel(f, a, b, e.hi, e.lo, lat);
    e.done_edge = edges + 1 + lat;
    e.tag = tag;
    sbq.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    valid = 1'b1;
    aluop = 2'b10;
    funct = f;
    srca  = a;
    srcb  = b;
    @(negedge clk);
    valid = 1'b0;
    aluop = 2'b00;
    funct = 6'b000000;
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait idle: busy=1 required=0 after %0d cycles", limit);
    end
  endtask

  task automatic moveTo(input logic [5:0] f, input logic [W-1:0] v);
    @(negedge clk);
    valid = 1'b1;
    aluop = 2'b10;
    funct = f;
    srca  = v;
    @(negedge clk);
    valid = 1'b0;
    if (f == F_MTHI) begin
      model_hi = v;
      checkOutput("mthi idle", hi, v);
    end else begin
      model_lo = v;
      checkOutput("mtlo idle", lo, v);
    end
  endtask

  function automatic logic [W-1:0] randOperand();
    case ($urandom_range(0, 5))
      0: randOperand = '0;
      1: randOperand = W'($urandom_range(1, 15));
      2: randOperand = 32'h8000_0000;
      3: randOperand = 32'hFFFF_FFFF;
      default: randOperand = $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] old_hi, rhi, rlo, ra, rb;
    logic [5:0]   ops [4];
    int           lat, n;
    ops[0] = F_MULT;
    ops[1] = F_MULTU;
    ops[2] = F_DIV;
    ops[3] = F_DIVU;

    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset hi", hi, '0);
    checkOutput("reset lo", lo, '0);
    rst_n = 1'b1;

    // Decode table
    decodeCheck(2'b00, F_SUB, 1'b1);
    decodeCheck(2'b01, F_ADD, 1'b1);
    decodeCheck(2'b10, F_ADD, 1'b1);
    decodeCheck(2'b10, F_SUB, 1'b1);
    decodeCheck(2'b10, F_AND, 1'b1);
    decodeCheck(2'b10, F_OR, 1'b1);
    decodeCheck(2'b10, F_SLT, 1'b1);
    decodeCheck(2'b10, 6'b111111, 1'b1);
    decodeCheck(2'b10, 6'b111111, 1'b0);
    decodeCheck(2'b11, F_SUB, 1'b1);
    decodeCheck(2'b10, F_MFHI, 1'b1);
    decodeCheck(2'b10, F_MFLO, 1'b1);
    for (int i = 0; i < 16; i++)
      decodeCheck(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

    // Directed arithmetic
    applyStimulus(F_MULT, 32'hFFFF_FFFF, 32'h0000_0002, "mult -1*2");
    waitIdle(100);
    applyStimulus(F_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
    waitIdle(100);
    applyStimulus(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div -7/2");
    waitIdle(100);
    applyStimulus(F_DIVU, 32'h0000_0007, 32'h0000_0000, "divu by zero");
    waitIdle(100);
    applyStimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    waitIdle(100);
    applyStimulus(F_MULT, 32'h1234_5678, 32'h0000_0003, "mult by 3");
    waitIdle(100);
    applyStimulus(F_MULTU, 32'h1234_5678, 32'h0000_0000, "mult by 0");
    waitIdle(100);

    // mthi/mtlo while idle
    moveTo(F_MTHI, 32'h1234_5678);
    moveTo(F_MTLO, 32'h0BAD_F00D);

    // ALU op during busy passes through; mflo holds until busy falls
    refModel(F_MULT, 32'h0000_1234, 32'hFFFF_0003, rhi, rlo, lat);
    applyStimulus(F_MULT, 32'h0000_1234, 32'hFFFF_0003, "mult then mflo");
    valid = 1'b1;
    aluop = 2'b10;
    funct = F_ADD;
    #1;
    checkOutput("add during busy stall", stall, 1'b0);
    checkOutput("add during busy alucontrol", alucontrol, 3'b010);
    @(negedge clk);
    funct = F_MFLO;
    n = 0;
    while (busy && n < 100) begin
      #1;
      checkOutput("mflo stall while busy", stall, 1'b1);
      @(negedge clk);
      n++;
    end
    #1;
    checkOutput("mflo stall released", stall, 1'b0);
    checkOutput("mflo res_sel", res_sel, 2'b10);
    checkOutput("mflo lo", lo, rlo);
    valid = 1'b0;

    // mthi while busy is stalled and HI keeps its old value
    old_hi = model_hi;
    applyStimulus(F_DIVU, 32'hCAFE_0000, 32'h0000_0123, "divu under mthi");
    valid = 1'b1;
    aluop = 2'b10;
    funct = F_MTHI;
    srca  = 32'hDEAD_BEEF;
    n = 0;
    while (busy && n < 100) begin
      #1;
      checkOutput("mthi stall while busy", stall, 1'b1);
      checkOutput("hi held while busy", hi, old_hi);
      @(negedge clk);
      n++;
    end
    valid = 1'b0;
    waitIdle(100);

    // Asynchronous reset in the middle of a divide (counter at 10)
    applyStimulus(F_DIV, 32'h7654_3210, 32'h0000_0013, "div aborted");
    repeat (22) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort hi", hi, '0);
    checkOutput("abort lo", lo, '0);
    sbq.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised operations with occasional mthi/mtlo
    for (int i = 0; i < 24; i++) begin
      ra = randOperand();
      rb = randOperand();
      applyStimulus(ops[$urandom_range(0, 3)], ra, rb, $sformatf("rand op %0d", i));
      waitIdle(100);
      if ($urandom_range(0, 3) == 0)
        moveTo(($urandom_range(0, 1) == 0) ? F_MTHI : F_MTLO, $urandom);
    end

    waitIdle(100);
    @(negedge clk);
    checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
